// File: rtl/placeholder_pkg.sv
// Shared constants and LFSR step function for the place_holder_selfcheck health block.
package placeholder_pkg;

  localparam logic [63:0] DEF_SEED        = 64'hACE1_0001;
  localparam logic [63:0] DEF_TAPS        = 64'h8020_0003;
  localparam int          DEF_FAIL_THRESH = 1;
  localparam logic [7:0]  CNT_MAX         = 8'd255;

  // Fibonacci step: shift left, feed back the parity of the tapped bits into bit 0.
  // Callers pass state zero-extended to 64 bits and truncate the result.
  function automatic logic [63:0] lfsr_next(input logic [63:0] state,
                                            input logic [63:0] taps);
    return {state[62:0], ^(state & taps)};
  endfunction

endpackage

// File: rtl/placeholder_lfsr.sv
// One free-running Fibonacci LFSR, reloaded with SEED on reset.
module placeholder_lfsr
  import placeholder_pkg::*;
#(
  parameter int          WIDTH = 32,
  parameter logic [63:0] SEED  = DEF_SEED,
  parameter logic [63:0] TAPS  = DEF_TAPS
) (
  input  logic             CLK,
  input  logic             RST,
  output logic [WIDTH-1:0] state_o
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;

  // Next state from the shared step function, narrowed back to WIDTH.
  always_comb begin
    state_d = WIDTH'(lfsr_next(64'(state_q), TAPS));
  end

  // State register: seed load on reset, otherwise step every cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= WIDTH'(SEED);
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/place_holder_selfcheck.sv
// Self-check / liveness block: primary and shadow LFSRs run in lockstep; any
// divergence, an all-zero lockup, or an injected fault counts as a mismatch.
// FAIL_THRESH consecutive mismatches latch a sticky fault (out = 0) until RST.
// Optional macro PLACEHOLDER_FAULT_INJECT_EN adds an `inject` input that forces
// a mismatch for one cycle without disturbing LFSR state.
module place_holder_selfcheck
  import placeholder_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter logic [63:0] SEED        = DEF_SEED,
  parameter logic [63:0] TAPS        = DEF_TAPS,
  parameter int          FAIL_THRESH = DEF_FAIL_THRESH
) (
  input  logic CLK,
  input  logic RST,
`ifdef PLACEHOLDER_FAULT_INJECT_EN
  input  logic inject,
`endif
  output logic out
);

  localparam logic [8:0] THRESH = 9'(FAIL_THRESH);

  logic [WIDTH-1:0] prim_q;
  logic [WIDTH-1:0] shad_q;
  logic [7:0]       cnt_q;
  logic [7:0]       cnt_d;
  logic             fail_q = 1'b0;  // power-up healthy, before any clock or reset
  logic             fail_d;
  logic             mismatch;
  logic [8:0]       cnt_inc;

  // Saturating run-length increment.
  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == CNT_MAX) ? CNT_MAX : c + 8'd1;
  endfunction

  placeholder_lfsr #(
    .WIDTH (WIDTH),
    .SEED  (SEED),
    .TAPS  (TAPS)
  ) u_prim (
    .CLK     (CLK),
    .RST     (RST),
    .state_o (prim_q)
  );

  placeholder_lfsr #(
    .WIDTH (WIDTH),
    .SEED  (SEED),
    .TAPS  (TAPS)
  ) u_shad (
    .CLK     (CLK),
    .RST     (RST),
    .state_o (shad_q)
  );

  // Mismatch detection, run counter and fault-latch next state.
  always_comb begin
    mismatch = (prim_q != shad_q) || (prim_q == '0);
`ifdef PLACEHOLDER_FAULT_INJECT_EN
    mismatch = mismatch || inject;
`endif
    cnt_inc = {1'b0, cnt_q} + 9'd1;
    cnt_d   = '0;
    fail_d  = fail_q;
    if (mismatch) begin
      cnt_d = sat_inc(cnt_q);
      if (cnt_inc >= THRESH) begin
        fail_d = 1'b1;
      end
    end
  end

  // Control registers: reset wins over any mismatch run in progress.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q  <= '0;
      fail_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      fail_q <= fail_d;
    end
  end

  assign out = ~fail_q;

endmodule

// File: tb/tb_place_holder_selfcheck.sv
// Directed bench for place_holder_selfcheck: default instance, threshold-3
// instance, and two lockup (SEED = 0) instances with thresholds 1 and 3.
// Injection scenarios compile in only with PLACEHOLDER_FAULT_INJECT_EN.
module tb_place_holder_selfcheck;

  localparam logic [31:0] M_SEED = 32'hACE1_0001;
  localparam logic [31:0] M_TAPS = 32'h8020_0003;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic inj1 = 1'b0;
  logic inj3 = 1'b0;
  logic out_a, out_t3, out_z1, out_z3;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] model;

  always #5 CLK = ~CLK;

  place_holder_selfcheck #(.FAIL_THRESH(1)) dut (
    .CLK(CLK), .RST(RST),
`ifdef PLACEHOLDER_FAULT_INJECT_EN
    .inject(inj1),
`endif
    .out(out_a));

  place_holder_selfcheck #(.FAIL_THRESH(3)) dut3 (
    .CLK(CLK), .RST(RST),
`ifdef PLACEHOLDER_FAULT_INJECT_EN
    .inject(inj3),
`endif
    .out(out_t3));

  place_holder_selfcheck #(.SEED(64'd0), .FAIL_THRESH(1)) dutz1 (
    .CLK(CLK), .RST(RST),
`ifdef PLACEHOLDER_FAULT_INJECT_EN
    .inject(1'b0),
`endif
    .out(out_z1));

  place_holder_selfcheck #(.SEED(64'd0), .FAIL_THRESH(3)) dutz3 (
    .CLK(CLK), .RST(RST),
`ifdef PLACEHOLDER_FAULT_INJECT_EN
    .inject(1'b0),
`endif
    .out(out_z3));

  function automatic logic [31:0] mnext(input logic [31:0] s);
    return {s[30:0], ^(s & M_TAPS)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #1;
    chk("t0_out_a",  64'(out_a),  64'd1);
    chk("t0_out_t3", 64'(out_t3), 64'd1);
    chk("t0_out_z1", 64'(out_z1), 64'd1);
    chk("t0_out_z3", 64'(out_z3), 64'd1);

    RST = 1'b1;
    step();
    step();
    chk("rst_out_a",  64'(out_a),  64'd1);
    chk("rst_prim",   64'(dut.prim_q), 64'(M_SEED));
    chk("rst_shad",   64'(dut.shad_q), 64'(M_SEED));
    chk("rst_out_z1", 64'(out_z1), 64'd1);
    chk("rst_prim_z", 64'(dutz1.prim_q), 64'd0);
    RST = 1'b0;
    model = M_SEED;

    for (int k = 1; k <= 1000; k++) begin
      step();
      model = mnext(model);
      chk("run_prim",   64'(dut.prim_q), 64'(model));
      chk("run_shad",   64'(dut.shad_q), 64'(model));
      chk("run_out_a",  64'(out_a),  64'd1);
      chk("run_out_t3", 64'(out_t3), 64'd1);
      if (k <= 6) begin
        chk("lock_out_z1", 64'(out_z1), 64'd0);
        chk("lock_out_z3", 64'(out_z3), (k >= 3) ? 64'd0 : 64'd1);
      end
    end

    // Reset in the middle of a latched lockup fault clears it on that edge.
    RST = 1'b1;
    step();
    chk("rw_out_z1", 64'(out_z1), 64'd1);
    chk("rw_out_z3", 64'(out_z3), 64'd1);
    chk("rw_prim_a", 64'(dut.prim_q), 64'(M_SEED));
    RST = 1'b0;
    step();
    chk("rel_out_z1", 64'(out_z1), 64'd0);
    chk("rel_out_z3", 64'(out_z3), 64'd1);
    step();
    chk("rel2_out_z3", 64'(out_z3), 64'd1);
    step();
    chk("rel3_out_z3", 64'(out_z3), 64'd0);

`ifdef PLACEHOLDER_FAULT_INJECT_EN
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    model = M_SEED;
    for (int k = 0; k < 10; k++) begin
      step();
      model = mnext(model);
    end
    chk("pre_inj_out", 64'(out_a), 64'd1);
    inj1 = 1'b1;
    step();
    model = mnext(model);
    inj1 = 1'b0;
    chk("inj_out",  64'(out_a), 64'd0);
    chk("inj_prim", 64'(dut.prim_q), 64'(model));
    chk("inj_t3",   64'(out_t3), 64'd1);
    for (int k = 0; k < 100; k++) begin
      step();
      model = mnext(model);
      chk("sticky_out",  64'(out_a), 64'd0);
      chk("sticky_prim", 64'(dut.prim_q), 64'(model));
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("clr_out",  64'(out_a), 64'd1);
    chk("clr_prim", 64'(dut.prim_q), 64'(M_SEED));
    for (int k = 0; k < 100; k++) begin
      step();
      chk("clr_run_out", 64'(out_a), 64'd1);
    end

    // Threshold 3: a run of two clears, a run of three latches.
    inj3 = 1'b1;
    step();
    chk("t3_run2_e1", 64'(out_t3), 64'd1);
    step();
    chk("t3_run2_e2", 64'(out_t3), 64'd1);
    inj3 = 1'b0;
    step();
    chk("t3_gap", 64'(out_t3), 64'd1);
    inj3 = 1'b1;
    step();
    chk("t3_run3_e1", 64'(out_t3), 64'd1);
    step();
    chk("t3_run3_e2", 64'(out_t3), 64'd1);
    step();
    chk("t3_run3_e3", 64'(out_t3), 64'd0);
    inj3 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_sticky", 64'(out_t3), 64'd0);
    end
    chk("t3_other_ok", 64'(out_a), 64'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/place_holder_selfcheck.md
Name: place_holder_selfcheck

Overview:
- Free-running self-check/liveness block with a single status output `out`.
- `out` = 1 means healthy. `out` = 0 means a latched internal consistency fault.
- Internally, a primary LFSR and a shadow LFSR step in lockstep and are compared every cycle.
- Instantiated several times as a sanity/health indicator beside top-level test logic. Status consumers require `out` == 1 in normal operation.

Parameters:
- WIDTH, 32: LFSR width in bits (legal 8..64).
- SEED, 32'hACE1_0001: reset value loaded into both LFSRs (truncated/zero-extended to WIDTH). SEED = 0 is legal and is flagged as lockup.
- TAPS, 32'h8020_0003: Fibonacci feedback mask; feedback = XOR of (state & TAPS).
- FAIL_THRESH, 1: number of consecutive mismatching cycles that latches a fault (legal 1..255).

Ports:
- CLK  input  1  clock, all state on rising edge.
- RST  input  1  synchronous active-high reset.
- out  output 1  health flag: 1 = healthy, 0 = fault latched (sticky until RST).

Behaviour:
- Reset, synchronous: on a rising CLK edge with RST = 1:
  - prim_q and shad_q are loaded with SEED.
  - The consecutive-mismatch counter cnt_q is cleared to 0.
  - The fault flag fail_q is cleared to 0.
- out = ~fail_q, purely combinational from the register.
- fail_q carries a power-up initial value of 0, so `out` reads 1 from time zero, before any clock edge or reset.
- Step rule, each non-reset edge: next = {state[WIDTH-2:0], ^(state & TAPS)}. Applied identically to prim_q and shad_q.
- Mismatch in the current cycle when any of these holds:
  - prim_q != shad_q
  - prim_q == 0 (lockup)
  - the injected fault is active (see Optional Feature)
- cnt_q update:
  - If mismatch: cnt_q <= cnt_q + 1, saturating at 255.
  - Else: cnt_q <= 0.
- Fault latch: fail_q <= 1 at the edge where mismatch is true and cnt_q + 1 >= FAIL_THRESH.
- Latency: with FAIL_THRESH = 1, `out` falls immediately after the edge that ends the first mismatching cycle.
- Sticky: once fail_q = 1, only RST clears it. The LFSRs keep stepping regardless.
- RST during a mismatch run: reset wins. The counter and flag clear and the LFSRs reload on that edge.
- SEED = 0: the first cycle after reset release is a lockup mismatch. `out` falls FAIL_THRESH edges after release.
- No other outputs. The block has no handshakes.

Optional Feature:
- Macro: PLACEHOLDER_FAULT_INJECT_EN.
- With the macro defined:
  - Extra port `inject`, input, 1 bit.
  - inject = 1 forces a mismatch in that cycle only. LFSR state is not corrupted.
  - This is used to verify the threshold and the sticky latch.
- Without the macro: no `inject` port. The mismatch logic has only the equality and lockup terms.

Decomposition:
- Shared package placeholder_pkg holds:
  - default constants: SEED, TAPS, FAIL_THRESH
  - CNT_MAX = 255
  - a function lfsr_next(state, taps)
- One natural sub-module, placeholder_lfsr: WIDTH, SEED, TAPS; CLK, RST, state output.
  - Instantiated twice (primary and shadow).
  - The compare, counter and latch logic stay in the top module.

Test Plan:
- Time zero, no clock edges yet -> `out` == 1.
- RST high 2 cycles, release, run 1000 cycles with defaults -> `out` == 1 every cycle; prim_q == shad_q throughout.
- (MACRO on, FAIL_THRESH = 1) inject pulsed 1 cycle at cycle 10 after release -> `out` == 0 from the following edge and stays 0 for 100 more cycles.
- After that fault, RST high 1 cycle -> `out` == 1 after the edge; prim_q == SEED; stays 1 for 100 cycles.
- (MACRO on, FAIL_THRESH = 3):
  - inject high 2 consecutive cycles -> `out` stays 1 (counter returns to 0).
  - inject high 3 consecutive cycles -> `out` == 0 after the third edge.
- SEED = 0, FAIL_THRESH = 1: release RST -> `out` == 0 after the first edge following release.
